// File: rtl/countdown_timer.sv
// countdown_timer: two-digit BCD round timer counting down from a preset to 00.
// It advances by one step on each tick while running. The ones digit borrows
// from the tens digit. It flags expiry when the count reaches 00.
// The block supports start (load the preset and run), pause (toggle) and asynchronous reset.
// Optional feature macro: COUNTDOWN_AUTORELOAD_EN. When it is defined, the timer
// reloads the preset on the tick after reaching 00 and does not stop in DONE.
module countdown_timer #(
    parameter int START_TENS = 6,
    parameter int START_ONES = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       start,
    input  logic       pause,
    output logic [3:0] count_tens,
    output logic [3:0] count_ones,
    output logic       borrow,
    output logic       expired,
    output logic       running
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [3:0] PRESET_TENS = 4'(START_TENS);
    localparam logic [3:0] PRESET_ONES = 4'(START_ONES);
    localparam bit         PRESET_ZERO = (START_TENS == 0) && (START_ONES == 0);

    // An out-of-range preset digit would let the counter leave 0..9 forever,
    // so refuse to elaborate such a configuration.
    if ((START_TENS < 0) || (START_TENS > 9)) begin : g_bad_tens
        $error("countdown_timer: START_TENS must be in 0..9");
    end
    if ((START_ONES < 0) || (START_ONES > 9)) begin : g_bad_ones
        $error("countdown_timer: START_ONES must be in 0..9");
    end

    state_t     state;
    state_t     state_next;
    logic [3:0] tens_next;
    logic [3:0] ones_next;
    logic       borrow_next;
    logic       expired_next;

    logic [3:0] dec_tens;
    logic [3:0] dec_ones;
    logic       dec_borrow;
    logic       dec_zero;
    logic       at_zero;

    assign at_zero = (count_tens == 4'd0) && (count_ones == 4'd0);

    // One BCD decrement step of the current count, saturating at 00.
    always_comb begin
        dec_tens   = count_tens;
        dec_ones   = count_ones;
        dec_borrow = 1'b0;
        if (count_ones != 4'd0) begin
            dec_ones = count_ones - 4'd1;
        end else if (count_tens != 4'd0) begin
            dec_ones   = 4'd9;
            dec_tens   = count_tens - 4'd1;
            dec_borrow = 1'b1;
        end
        dec_zero = (dec_tens == 4'd0) && (dec_ones == 4'd0);
    end

    // Next-state and next-output logic: start beats pause beats tick in every state.
    always_comb begin
        state_next   = state;
        tens_next    = count_tens;
        ones_next    = count_ones;
        borrow_next  = 1'b0;
        expired_next = 1'b0;

        if (start) begin
            tens_next = PRESET_TENS;
            ones_next = PRESET_ONES;
            if (PRESET_ZERO) begin
                expired_next = 1'b1;
`ifdef COUNTDOWN_AUTORELOAD_EN
                state_next   = RUN;
`else
                state_next   = DONE;
`endif
            end else begin
                state_next = RUN;
            end
        end else begin
            case (state)
                IDLE: begin
                end
                RUN: begin
                    if (pause) begin
                        state_next = PAUSE;
                    end else if (tick) begin
`ifdef COUNTDOWN_AUTORELOAD_EN
                        if (at_zero) begin
                            tens_next    = PRESET_TENS;
                            ones_next    = PRESET_ONES;
                            expired_next = PRESET_ZERO;
                        end else begin
                            tens_next    = dec_tens;
                            ones_next    = dec_ones;
                            borrow_next  = dec_borrow;
                            expired_next = dec_zero;
                        end
`else
                        if (at_zero) begin
                            state_next = DONE;
                        end else begin
                            tens_next    = dec_tens;
                            ones_next    = dec_ones;
                            borrow_next  = dec_borrow;
                            expired_next = dec_zero;
                            if (dec_zero) begin
                                state_next = DONE;
                            end
                        end
`endif
                    end
                end
                PAUSE: begin
                    if (pause) begin
                        state_next = RUN;
                    end
                end
                DONE: begin
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    // State and output registers; reset returns to the preset in IDLE at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            count_tens <= PRESET_TENS;
            count_ones <= PRESET_ONES;
            borrow     <= 1'b0;
            expired    <= 1'b0;
            running    <= 1'b0;
        end else begin
            state      <= state_next;
            count_tens <= tens_next;
            count_ones <= ones_next;
            borrow     <= borrow_next;
            expired    <= expired_next;
            running    <= (state_next == RUN);
        end
    end

`ifndef SYNTHESIS
    // Simulation sanity checks on the registered outputs.
    always @(posedge clk) begin
        if (!rst) begin
            assert (count_tens <= 4'd9 && count_ones <= 4'd9);
            assert (!expired || (count_tens == 4'd0 && count_ones == 4'd0));
            assert (!borrow || count_ones == 4'd9);
            assert (running == (state == RUN));
        end
    end
`endif

endmodule

// File: tb/tb_countdown_timer.sv
// tb_countdown_timer: scoreboard bench for countdown_timer.
// There are three instances, with presets 6:0, 0:2 and 0:0.
// Stimulus pushes the expected outputs into a queue. A monitor process pops
// one expectation per clock, after the edge, and compares.
module tb_countdown_timer;

`ifdef COUNTDOWN_AUTORELOAD_EN
    localparam bit AUTO_RELOAD = 1'b1;
`else
    localparam bit AUTO_RELOAD = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] start = 3'b000;
    logic [2:0] pause = 3'b000;
    logic [2:0] tick  = 3'b000;

    logic [3:0] count_tens [3];
    logic [3:0] count_ones [3];
    logic       borrow_out [3];
    logic       expired_out[3];
    logic       running_out[3];

    typedef struct {
        int         sel;
        logic [3:0] tens;
        logic [3:0] ones;
        logic       brw;
        logic       exp;
        logic       run;
        string      name;
    } expect_t;

    expect_t sb_q[$];
    int errors = 0;
    int checks = 0;

    countdown_timer #(.START_TENS(6), .START_ONES(0)) u_dut0 (
        .clk(clk), .rst(rst), .tick(tick[0]), .start(start[0]), .pause(pause[0]),
        .count_tens(count_tens[0]), .count_ones(count_ones[0]),
        .borrow(borrow_out[0]), .expired(expired_out[0]), .running(running_out[0])
    );

    countdown_timer #(.START_TENS(0), .START_ONES(2)) u_dut1 (
        .clk(clk), .rst(rst), .tick(tick[1]), .start(start[1]), .pause(pause[1]),
        .count_tens(count_tens[1]), .count_ones(count_ones[1]),
        .borrow(borrow_out[1]), .expired(expired_out[1]), .running(running_out[1])
    );

    countdown_timer #(.START_TENS(0), .START_ONES(0)) u_dut2 (
        .clk(clk), .rst(rst), .tick(tick[2]), .start(start[2]), .pause(pause[2]),
        .count_tens(count_tens[2]), .count_ones(count_ones[2]),
        .borrow(borrow_out[2]), .expired(expired_out[2]), .running(running_out[2])
    );

    // 10-unit clock
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int sel,
                               input logic [3:0] t, input logic [3:0] o,
                               input logic b, input logic e, input logic r);
        logic [10:0] act;
        logic [10:0] req;
        act = {count_tens[sel], count_ones[sel], borrow_out[sel], expired_out[sel], running_out[sel]};
        req = {t, o, b, e, r};
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s dut%0d: got %0d:%0d borrow=%0b expired=%0b running=%0b, want %0d:%0d borrow=%0b expired=%0b running=%0b",
                     name, sel, act[10:7], act[6:3], act[2], act[1], act[0],
                     t, o, b, e, r);
        end
    endtask

    task automatic clearInputs();
        start = 3'b000;
        pause = 3'b000;
        tick  = 3'b000;
    endtask

    // Drive one cycle of inputs on dut 'sel' and queue the outputs expected after the next edge
    task automatic applyStimulus(input int sel, input logic s, input logic p, input logic t,
                                 input logic [3:0] et, input logic [3:0] eo,
                                 input logic eb, input logic ee, input logic er,
                                 input string name);
        expect_t e;
        @(negedge clk);
        clearInputs();
        start[sel] = s;
        pause[sel] = p;
        tick[sel]  = t;
        e.sel  = sel;
        e.tens = et;
        e.ones = eo;
        e.brw  = eb;
        e.exp  = ee;
        e.run  = er;
        e.name = name;
        sb_q.push_back(e);
    endtask

    // Monitor: one expectation per clock edge, sampled just after the edge
    initial begin
        expect_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                checkOutput(e.name, e.sel, e.tens, e.ones, e.brw, e.exp, e.run);
            end
        end
    end

    // Watchdog so the run always ends
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, want finish before it");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int v;
        $display("[TB] countdown_timer bench, auto reload=%0b", AUTO_RELOAD);

        // Reset values
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("reset_state", 0, 4'd6, 4'd0, 1'b0, 1'b0, 1'b0);
        checkOutput("reset_state", 1, 4'd0, 4'd2, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        // IDLE ignores tick and pause
        applyStimulus(0, 1'b0, 1'b0, 1'b1, 4'd6, 4'd0, 1'b0, 1'b0, 1'b0, "idle_tick");
        applyStimulus(0, 1'b0, 1'b0, 1'b1, 4'd6, 4'd0, 1'b0, 1'b0, 1'b0, "idle_tick2");
        applyStimulus(0, 1'b0, 1'b1, 1'b0, 4'd6, 4'd0, 1'b0, 1'b0, 1'b0, "idle_pause");

        // Start, first tick borrows 6:0 -> 5:9
        applyStimulus(0, 1'b1, 1'b0, 1'b0, 4'd6, 4'd0, 1'b0, 1'b0, 1'b1, "start_load");
        applyStimulus(0, 1'b0, 1'b0, 1'b1, 4'd5, 4'd9, 1'b1, 1'b0, 1'b1, "first_tick_borrow");
        applyStimulus(0, 1'b0, 1'b0, 1'b0, 4'd5, 4'd9, 1'b0, 1'b0, 1'b1, "borrow_one_cycle");

        // Count 5:9 down to 4:3
        for (int k = 1; k <= 16; k++) begin
            v = 59 - k;
            applyStimulus(0, 1'b0, 1'b0, 1'b1, 4'(v / 10), 4'(v % 10),
                          (v % 10) == 9, 1'b0, 1'b1, "run_count");
        end

        // Pause holds 4:3 through ticks, resume then tick -> 4:2
        applyStimulus(0, 1'b0, 1'b1, 1'b0, 4'd4, 4'd3, 1'b0, 1'b0, 1'b0, "pause_enter");
        for (int k = 0; k < 3; k++) begin
            applyStimulus(0, 1'b0, 1'b0, 1'b1, 4'd4, 4'd3, 1'b0, 1'b0, 1'b0, "pause_hold");
        end
        applyStimulus(0, 1'b0, 1'b1, 1'b0, 4'd4, 4'd3, 1'b0, 1'b0, 1'b1, "pause_resume");
        applyStimulus(0, 1'b0, 1'b0, 1'b1, 4'd4, 4'd2, 1'b0, 1'b0, 1'b1, "resume_tick");
        // pause and tick together: pause wins, tick dropped
        applyStimulus(0, 1'b0, 1'b1, 1'b1, 4'd4, 4'd2, 1'b0, 1'b0, 1'b0, "pause_beats_tick");
        applyStimulus(0, 1'b0, 1'b1, 1'b0, 4'd4, 4'd2, 1'b0, 1'b0, 1'b1, "pause_resume2");

        // Count 4:2 down to 3:5
        for (int k = 1; k <= 7; k++) begin
            v = 42 - k;
            applyStimulus(0, 1'b0, 1'b0, 1'b1, 4'(v / 10), 4'(v % 10),
                          (v % 10) == 9, 1'b0, 1'b1, "run_count2");
        end

        // start and tick together at 3:5: start wins
        applyStimulus(0, 1'b1, 1'b0, 1'b1, 4'd6, 4'd0, 1'b0, 1'b0, 1'b1, "start_beats_tick");
        applyStimulus(0, 1'b0, 1'b0, 1'b1, 4'd5, 4'd9, 1'b1, 1'b0, 1'b1, "restart_tick");
        applyStimulus(0, 1'b0, 1'b0, 1'b1, 4'd5, 4'd8, 1'b0, 1'b0, 1'b1, "restart_tick2");

        // Asynchronous reset mid-cycle aborts the count immediately
        @(posedge clk);
        #3;
        clearInputs();
        rst = 1'b1;
        #1;
        checkOutput("async_reset", 0, 4'd6, 4'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(0, 1'b0, 1'b0, 1'b1, 4'd6, 4'd0, 1'b0, 1'b0, 1'b0, "idle_after_reset");

        // Preset 0:2 down to 00, expiry and what follows
        applyStimulus(1, 1'b1, 1'b0, 1'b0, 4'd0, 4'd2, 1'b0, 1'b0, 1'b1, "short_start");
        applyStimulus(1, 1'b0, 1'b0, 1'b1, 4'd0, 4'd1, 1'b0, 1'b0, 1'b1, "short_tick1");
        applyStimulus(1, 1'b0, 1'b0, 1'b1, 4'd0, 4'd0, 1'b0, 1'b1, AUTO_RELOAD, "reach_zero");
`ifdef COUNTDOWN_AUTORELOAD_EN
        applyStimulus(1, 1'b0, 1'b0, 1'b1, 4'd0, 4'd2, 1'b0, 1'b0, 1'b1, "auto_reload");
        applyStimulus(1, 1'b0, 1'b1, 1'b0, 4'd0, 4'd2, 1'b0, 1'b0, 1'b0, "reload_pause");
`else
        applyStimulus(1, 1'b0, 1'b0, 1'b1, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, "done_hold");
        applyStimulus(1, 1'b0, 1'b1, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, "done_pause");
`endif
        applyStimulus(1, 1'b1, 1'b0, 1'b0, 4'd0, 4'd2, 1'b0, 1'b0, 1'b1, "restart_short");
        applyStimulus(1, 1'b0, 1'b0, 1'b1, 4'd0, 4'd1, 1'b0, 1'b0, 1'b1, "restart_tick1");
        applyStimulus(1, 1'b0, 1'b0, 1'b1, 4'd0, 4'd0, 1'b0, 1'b1, AUTO_RELOAD, "restart_zero");

        // Preset 00: expiry on start itself
        applyStimulus(2, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 1'b1, AUTO_RELOAD, "zero_preset_start");
        applyStimulus(2, 1'b0, 1'b0, 1'b1, 4'd0, 4'd0, 1'b0, AUTO_RELOAD, AUTO_RELOAD, "zero_preset_tick");
        applyStimulus(2, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, AUTO_RELOAD, "zero_preset_quiet");

        // Drain the scoreboard
        @(negedge clk);
        clearInputs();
        repeat (3) @(negedge clk);
        if (sb_q.size() != 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL scoreboard_drain: %0d entries left, want 0", sb_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
